// File: rtl/subgraph_feature_gather.sv
// Purpose: walks the subgraph index BRAM, gathers each node's layer-N features, quantises them
//          and writes compacted sparse H rows ({value, col_idx}) plus per-node node_info words.
// Latency: NUM_FEATURE_OUT+3 cycles per index entry; done_o pulses in the cycle after the last entry.
// Backpressure: none downstream (BRAM writes always land); new requests are held off while rdy is low.
//
// Ports: clk/rst_n (async active-low); subgraph_vld_i/subgraph_rdy_o/num_entries_i request handshake;
//        subgraph_bram_* and feat_bram_* are 1-cycle-latency read ports; h_data_bram_* and
//        node_info_bram_* are write ports; done_o pass pulse; error_o/overflow_o sticky flags.
// Option: define SUBGRAPH_FEATURE_GATHER_RELU_EN to clamp negative features to zero before quantising.
module subgraph_feature_gather #(
    parameter int DATA_WIDTH        = 8,
    parameter int NEW_FEATURE_WIDTH = 32,
    parameter int FRAC_SHIFT        = 0,
    parameter int NUM_FEATURE_OUT   = 16,
    parameter int TOTAL_NODES       = 13264,
    parameter int NODE_IDX_W        = 14,
    parameter int MAX_NODES         = 168,
    parameter int H_DATA_DEPTH      = 4096,
    parameter int NODE_INFO_DEPTH   = TOTAL_NODES,
    parameter int NEW_FEATURE_DEPTH = 2708*NUM_FEATURE_OUT,
    localparam int COL_W           = $clog2(NUM_FEATURE_OUT),
    localparam int H_DATA_WIDTH    = DATA_WIDTH + COL_W,
    localparam int IDX_W           = NODE_IDX_W + 2,
    localparam int POS_W           = $clog2(MAX_NODES),
    localparam int NODE_INFO_WIDTH = COL_W + 1 + POS_W + 1,
    localparam int NE_W            = $clog2(TOTAL_NODES) + 1,
    localparam int IA_W            = $clog2(TOTAL_NODES),
    localparam int FA_W            = $clog2(NEW_FEATURE_DEPTH),
    localparam int HA_W            = $clog2(H_DATA_DEPTH),
    localparam int NA_W            = $clog2(NODE_INFO_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         subgraph_vld_i,
    output logic                         subgraph_rdy_o,
    input  logic [NE_W-1:0]              num_entries_i,
    output logic [IA_W-1:0]              subgraph_bram_addrb,
    input  logic [IDX_W-1:0]             subgraph_bram_dout,
    output logic [FA_W-1:0]              feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0] feat_bram_dout,
    output logic [HA_W-1:0]              h_data_bram_addra,
    output logic [H_DATA_WIDTH-1:0]      h_data_bram_din,
    output logic                         h_data_bram_ena,
    output logic                         h_data_bram_wea,
    output logic [NA_W-1:0]              node_info_bram_addra,
    output logic [NODE_INFO_WIDTH-1:0]   node_info_bram_din,
    output logic                         node_info_bram_ena,
    output logic                         done_o,
    output logic                         error_o,
    output logic                         overflow_o
);

    typedef enum logic [2:0] {S_IDLE, S_IDX_RD, S_IDX_WAIT, S_FEAT, S_DRAIN, S_FINISH} state_t;

    // Signed saturation bounds held at feature width so the compare needs no narrowing.
    localparam logic signed [NEW_FEATURE_WIDTH-1:0] Q_MAX =
        {{(NEW_FEATURE_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [NEW_FEATURE_WIDTH-1:0] Q_MIN = ~Q_MAX;
    localparam logic [HA_W:0]      H_FULL  = (HA_W+1)'(H_DATA_DEPTH);
    localparam logic [POS_W-1:0]   POS_MAX = POS_W'(MAX_NODES - 1);
    localparam logic [COL_W-1:0]   F_LAST  = COL_W'(NUM_FEATURE_OUT - 1);

    state_t state, state_nxt;

    logic [NE_W-1:0]  num_entries, entry_cnt;
    logic [FA_W-1:0]  base;
    logic [COL_W-1:0] f_cnt, proc_col;
    logic             proc_vld;
    logic [HA_W:0]    h_ptr;
    logic [COL_W:0]   row_len;
    logic [POS_W-1:0] node_pos;
    logic             end_flag_r, first_entry, sub_open, error_r, overflow_r;

    logic                  idx_start, idx_end;
    logic [NODE_IDX_W-1:0] idx_node;
    assign idx_start = subgraph_bram_dout[IDX_W-1];
    assign idx_node  = subgraph_bram_dout[IDX_W-2:1];
    assign idx_end   = subgraph_bram_dout[0];

    logic last_entry, h_full, q_nz, h_we;
    assign last_entry = (entry_cnt + NE_W'(1)) == num_entries;
    assign h_full     = (h_ptr == H_FULL);

    // Quantiser: feature data is for the read issued last cycle (column proc_col).
    logic signed [NEW_FEATURE_WIDTH-1:0] feat_s, feat_sh;
    logic [DATA_WIDTH-1:0]               q;
    always_comb begin
        feat_s = $signed(feat_bram_dout);
`ifdef SUBGRAPH_FEATURE_GATHER_RELU_EN
        if (feat_s[NEW_FEATURE_WIDTH-1]) feat_s = '0;
`endif
        feat_sh = feat_s >>> FRAC_SHIFT;
        if (feat_sh > Q_MAX)      q = Q_MAX[DATA_WIDTH-1:0];
        else if (feat_sh < Q_MIN) q = Q_MIN[DATA_WIDTH-1:0];
        else                      q = feat_sh[DATA_WIDTH-1:0];
    end

    // row_len counts every nonzero value; only the BRAM write is dropped once H is full.
    assign q_nz = proc_vld && (q != '0);
    assign h_we = q_nz && !h_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt            = state;
        subgraph_rdy_o       = 1'b0;
        subgraph_bram_addrb  = '0;
        feat_bram_addrb      = '0;
        h_data_bram_addra    = '0;
        h_data_bram_din      = '0;
        h_data_bram_ena      = h_we;
        h_data_bram_wea      = h_we;
        node_info_bram_addra = '0;
        node_info_bram_din   = '0;
        node_info_bram_ena   = 1'b0;
        done_o               = 1'b0;
        error_o              = error_r;
        overflow_o           = overflow_r;
        if (h_we) begin
            h_data_bram_addra = HA_W'(h_ptr);
            h_data_bram_din   = {q, proc_col};
        end
        case (state)
            S_IDLE: begin
                subgraph_rdy_o = 1'b1;
                if (subgraph_vld_i) state_nxt = (num_entries_i == '0) ? S_FINISH : S_IDX_RD;
            end
            S_IDX_RD: begin
                subgraph_bram_addrb = IA_W'(entry_cnt);
                state_nxt           = S_IDX_WAIT;
            end
            S_IDX_WAIT: state_nxt = S_FEAT;
            S_FEAT: begin
                feat_bram_addrb = base + FA_W'(f_cnt);
                if (f_cnt == F_LAST) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // The last feature is still in flight, so fold it into row_len here.
                node_info_bram_ena   = 1'b1;
                node_info_bram_addra = NA_W'(entry_cnt);
                node_info_bram_din   = {row_len + (COL_W+1)'(q_nz), node_pos, end_flag_r};
                state_nxt            = last_entry ? S_FINISH : S_IDX_RD;
            end
            S_FINISH: begin
                done_o    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_entries <= '0;
            entry_cnt   <= '0;
            base        <= '0;
            f_cnt       <= '0;
            proc_col    <= '0;
            proc_vld    <= 1'b0;
            h_ptr       <= '0;
            row_len     <= '0;
            node_pos    <= '0;
            end_flag_r  <= 1'b0;
            first_entry <= 1'b0;
            sub_open    <= 1'b0;
            error_r     <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            proc_vld <= (state == S_FEAT);
            proc_col <= f_cnt;
            if (h_we) h_ptr <= h_ptr + (HA_W+1)'(1);
            if (q_nz) row_len <= row_len + (COL_W+1)'(1);
            if (state != S_IDLE && h_full) overflow_r <= 1'b1;
            case (state)
                S_IDLE: if (subgraph_vld_i) begin
                    num_entries <= num_entries_i;
                    entry_cnt   <= '0;
                    h_ptr       <= '0;
                    node_pos    <= '0;
                    first_entry <= 1'b1;
                    sub_open    <= 1'b0;
                    error_r     <= 1'b0;
                    overflow_r  <= 1'b0;
                end
                S_IDX_WAIT: begin
                    base        <= FA_W'(idx_node) * FA_W'(NUM_FEATURE_OUT);
                    end_flag_r  <= idx_end;
                    f_cnt       <= '0;
                    row_len     <= '0;
                    first_entry <= 1'b0;
                    sub_open    <= !idx_end;
                    // A missing start on the first entry still opens a fresh subgraph.
                    if (idx_start || first_entry) node_pos <= '0;
                    else if (node_pos == POS_MAX) error_r <= 1'b1;
                    else node_pos <= node_pos + POS_W'(1);
                    if ((idx_start && sub_open) || (first_entry && !idx_start)) error_r <= 1'b1;
                end
                S_FEAT:  f_cnt <= f_cnt + COL_W'(1);
                S_DRAIN: entry_cnt <= entry_cnt + NE_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_subgraph_feature_gather.sv
module tb_subgraph_feature_gather;

    localparam int NF = 16;
    localparam int MAXN = 168;

    typedef struct { int addr; int din; } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        vld_a = 1'b0, vld_b = 1'b0;
    logic [14:0] ne_a = '0, ne_b = '0;
    logic        rdy_a, rdy_b, done_a, done_b, err_a, err_b, ovf_a, ovf_b;
    logic [13:0] sg_addr_a, sg_addr_b;
    logic [15:0] sg_dout_a, sg_dout_b;
    logic [15:0] feat_addr_a, feat_addr_b;
    logic [31:0] feat_dout_a, feat_dout_b;
    logic [11:0] h_addr_a, h_din_a, h_din_b;
    logic [4:0]  h_addr_b;
    logic        h_ena_a, h_wea_a, h_ena_b, h_wea_b, ni_ena_a, ni_ena_b;
    logic [13:0] ni_addr_a, ni_addr_b, ni_din_a, ni_din_b;

    subgraph_feature_gather u_dut (
        .clk(clk), .rst_n(rst_n), .subgraph_vld_i(vld_a), .subgraph_rdy_o(rdy_a),
        .num_entries_i(ne_a), .subgraph_bram_addrb(sg_addr_a), .subgraph_bram_dout(sg_dout_a),
        .feat_bram_addrb(feat_addr_a), .feat_bram_dout(feat_dout_a),
        .h_data_bram_addra(h_addr_a), .h_data_bram_din(h_din_a), .h_data_bram_ena(h_ena_a),
        .h_data_bram_wea(h_wea_a), .node_info_bram_addra(ni_addr_a), .node_info_bram_din(ni_din_a),
        .node_info_bram_ena(ni_ena_a), .done_o(done_a), .error_o(err_a), .overflow_o(ovf_a));

    subgraph_feature_gather #(.H_DATA_DEPTH(20)) u_ovf (
        .clk(clk), .rst_n(rst_n), .subgraph_vld_i(vld_b), .subgraph_rdy_o(rdy_b),
        .num_entries_i(ne_b), .subgraph_bram_addrb(sg_addr_b), .subgraph_bram_dout(sg_dout_b),
        .feat_bram_addrb(feat_addr_b), .feat_bram_dout(feat_dout_b),
        .h_data_bram_addra(h_addr_b), .h_data_bram_din(h_din_b), .h_data_bram_ena(h_ena_b),
        .h_data_bram_wea(h_wea_b), .node_info_bram_addra(ni_addr_b), .node_info_bram_din(ni_din_b),
        .node_info_bram_ena(ni_ena_b), .done_o(done_b), .error_o(err_b), .overflow_o(ovf_b));

    // Shared memory contents, one registered read port per instance.
    logic [31:0] feat_mem [256];
    logic [15:0] idx_mem  [256];
    always @(posedge clk) begin
        sg_dout_a   <= idx_mem[sg_addr_a[7:0]];
        sg_dout_b   <= idx_mem[sg_addr_b[7:0]];
        feat_dout_a <= feat_mem[feat_addr_a[7:0]];
        feat_dout_b <= feat_mem[feat_addr_b[7:0]];
    end

    int n_assert = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    wr_t h_q[$], ni_q[$], exp_h[$], exp_ni[$];
    bit  exp_err, exp_ovf;

    always @(negedge clk) begin
        wr_t w;
        if (h_ena_a) begin w.addr = int'(h_addr_a); w.din = int'(h_din_a); h_q.push_back(w); end
        if (h_ena_b) begin w.addr = int'(h_addr_b); w.din = int'(h_din_b); h_q.push_back(w); end
        if (ni_ena_a) begin w.addr = int'(ni_addr_a); w.din = int'(ni_din_a); ni_q.push_back(w); end
        if (ni_ena_b) begin w.addr = int'(ni_addr_b); w.din = int'(ni_din_b); ni_q.push_back(w); end
        if (h_ena_a || h_wea_a) chk("wea_eq_ena", h_wea_a, h_ena_a);
    end

    bit  use_b = 1'b0;
    logic cur_done, cur_rdy, cur_err, cur_ovf;
    assign cur_done = use_b ? done_b : done_a;
    assign cur_rdy  = use_b ? rdy_b  : rdy_a;
    assign cur_err  = use_b ? err_b  : err_a;
    assign cur_ovf  = use_b ? ovf_b  : ovf_a;

    function automatic logic [15:0] ent(input int st, input int node, input int en);
        return 16'((st << 15) | (node << 1) | en);
    endfunction

    // Reference: walk entries, quantise each feature, compact nonzeros.
    task automatic model_pass(input int n, input int depth);
        int ptr, pos, v, rl, st, node, en;
        bit first, open;
        ptr = 0; pos = 0; first = 1; open = 0;
        exp_h.delete(); exp_ni.delete(); exp_err = 0;
        for (int e = 0; e < n; e++) begin
            wr_t w;
            st = int'(idx_mem[e][15]); node = int'(idx_mem[e][14:1]); en = int'(idx_mem[e][0]);
            if ((first && st == 0) || (st == 1 && open)) exp_err = 1;
            if (st == 1 || first) pos = 0;
            else if (pos == MAXN - 1) exp_err = 1;
            else pos++;
            first = 0; open = (en == 0);
            rl = 0;
            for (int f = 0; f < NF; f++) begin
                v = feat_mem[node*NF + f];
`ifdef SUBGRAPH_FEATURE_GATHER_RELU_EN
                if (v < 0) v = 0;
`endif
                if (v > 127) v = 127;
                if (v < -128) v = -128;
                if (v != 0) begin
                    rl++;
                    if (ptr < depth) begin
                        w.addr = ptr; w.din = ((v & 255) << 4) | f;
                        exp_h.push_back(w);
                        ptr++;
                    end
                end
            end
            w.addr = e; w.din = (rl << 9) | (pos << 1) | en;
            exp_ni.push_back(w);
        end
        exp_ovf = (ptr == depth);
    endtask

    task automatic run_pass(input int n, input bit b);
        int lat;
        bit seen;
        use_b = b;
        h_q.delete(); ni_q.delete();
        @(negedge clk);
        if (b) begin vld_b = 1'b1; ne_b = 15'(n); end
        else   begin vld_a = 1'b1; ne_a = 15'(n); end
        @(posedge clk);
        #1;
        vld_a = 1'b0; vld_b = 1'b0;
        lat = 0; seen = 0;
        for (int k = 0; k < 6000 && !seen; k++) begin
            @(negedge clk);
            if (k == 0) chk("rdy_drop", cur_rdy, 1'b0);
            if (cur_done) begin
                seen = 1;
                chk("rdy_low_at_done", cur_rdy, 1'b0);
            end else lat++;
        end
        chk("done_seen", seen, 1'b1);
        chk("latency", lat, 64'(19*n));
        @(negedge clk);
        chk("done_pulse", cur_done, 1'b0);
        chk("rdy_back", cur_rdy, 1'b1);
    endtask

    task automatic compare_pass(input string tag);
        chk({tag, " h_count"}, h_q.size(), exp_h.size());
        for (int i = 0; i < exp_h.size() && i < h_q.size(); i++) begin
            chk({tag, " h_addr"}, h_q[i].addr, exp_h[i].addr);
            chk({tag, " h_din"}, h_q[i].din, exp_h[i].din);
        end
        chk({tag, " ni_count"}, ni_q.size(), exp_ni.size());
        for (int i = 0; i < exp_ni.size() && i < ni_q.size(); i++) begin
            chk({tag, " ni_addr"}, ni_q[i].addr, exp_ni[i].addr);
            chk({tag, " ni_din"}, ni_q[i].din, exp_ni[i].din);
        end
        chk({tag, " error"}, cur_err, exp_err);
        chk({tag, " overflow"}, cur_ovf, exp_ovf);
    endtask

    task automatic load_plan_index();
        idx_mem[0] = ent(1, 2, 0);  idx_mem[1] = ent(0, 6, 0);
        idx_mem[2] = ent(0, 8, 0);  idx_mem[3] = ent(0, 10, 1);
        idx_mem[4] = ent(1, 0, 0);  idx_mem[5] = ent(0, 4, 1);
        idx_mem[6] = ent(1, 1, 0);  idx_mem[7] = ent(0, 3, 0);
        idx_mem[8] = ent(0, 5, 0);  idx_mem[9] = ent(0, 7, 1);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 256; i++) feat_mem[i] = 32'(i + 1);
    endtask

    initial begin
        int pos_exp[10] = '{0, 1, 2, 3, 0, 1, 0, 1, 2, 3};
        int v;
        for (int i = 0; i < 256; i++) idx_mem[i] = '0;
        load_ramp();

        // Reset state
        #3;
        chk("rst_rdy", rdy_a, 1'b1);
        chk("rst_done", done_a, 1'b0);
        chk("rst_h_ena", h_ena_a, 1'b0);
        chk("rst_h_wea", h_wea_a, 1'b0);
        chk("rst_ni_ena", ni_ena_a, 1'b0);
        chk("rst_err", err_a, 1'b0);
        chk("rst_ovf", ovf_a, 1'b0);
        chk("rst_sg_addr", sg_addr_a, 0);
        chk("rst_feat_addr", feat_addr_a, 0);
        chk("rst_ni_din", ni_din_a, 0);
        chk("rst_ovf_b", ovf_b, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Full pass over the ten-entry stream
        load_plan_index();
        model_pass(10, 4096);
        run_pass(10, 0);
        compare_pass("full");
        if (h_q.size() >= 160) begin
            chk("full_first_h", h_q[0].din, 12'h210);
            chk("full_node7_col0", h_q[144].din, 12'h710);
            chk("full_sat_col15", h_q[159].din, 12'h7FF);
        end
        for (int e = 0; e < 10 && e < ni_q.size(); e++) begin
            chk("full_row_len", ni_q[e].din >> 9, 16);
            chk("full_node_pos", (ni_q[e].din >> 1) & 255, pos_exp[e]);
        end
        chk("full_error", err_a, 1'b0);

        // Zero skip / negative handling on node 0
        for (int f = 0; f < NF; f++) feat_mem[f] = '0;
        feat_mem[1] = -32'sd5;
        feat_mem[3] = 32'd9;
        idx_mem[0] = ent(1, 0, 1);
        model_pass(1, 4096);
        run_pass(1, 0);
        compare_pass("zero_skip");
`ifdef SUBGRAPH_FEATURE_GATHER_RELU_EN
        chk("relu_count", h_q.size(), 1);
        if (h_q.size() >= 1) chk("relu_w0", h_q[0].din, 12'h093);
        if (ni_q.size() >= 1) chk("relu_row_len", ni_q[0].din >> 9, 1);
`else
        chk("signed_count", h_q.size(), 2);
        if (h_q.size() >= 2) begin
            chk("signed_w0", h_q[0].din, 12'hFB1);
            chk("signed_w1", h_q[1].din, 12'h093);
        end
        if (ni_q.size() >= 1) chk("signed_row_len", ni_q[0].din >> 9, 2);
`endif

        // Malformed first entry
        load_ramp();
        idx_mem[0] = ent(0, 3, 1);
        model_pass(1, 4096);
        run_pass(1, 0);
        compare_pass("malformed");
        chk("malformed_err", err_a, 1'b1);

        // Empty pass: done right after accept, no writes, sticky flags cleared
        model_pass(0, 4096);
        run_pass(0, 0);
        compare_pass("empty");

        // Randomised features and index streams
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 256; i++) begin
                case ($urandom_range(0, 4))
                    0: v = 0;
                    1: v = int'($urandom_range(0, 255)) - 128;
                    2: v = int'($urandom);
                    3: v = int'($urandom_range(1, 127));
                    default: v = int'($urandom_range(0, 1)) * 1000 - 500;
                endcase
                feat_mem[i] = 32'(v);
            end
            for (int e = 0; e < 12; e++)
                idx_mem[e] = ent((e == 0) ? int'($urandom_range(0, 3) != 0) : int'($urandom_range(0, 3) == 0),
                                 int'($urandom_range(0, 15)), int'($urandom_range(0, 2) == 0));
            model_pass(12, 4096);
            run_pass(12, 0);
            compare_pass("random");
        end

        // One long subgraph: node_pos saturates at MAX_NODES-1 and flags an error
        idx_mem[0] = ent(1, 4, 0);
        for (int e = 1; e < 170; e++) idx_mem[e] = ent(0, int'($urandom_range(0, 15)), 0);
        model_pass(170, 4096);
        run_pass(170, 0);
        compare_pass("long");
        if (ni_q.size() >= 170) chk("long_pos_sat", (ni_q[169].din >> 1) & 255, MAXN - 1);
        chk("long_err", err_a, 1'b1);

        // H BRAM overflow on the 20-deep instance
        load_ramp();
        idx_mem[0] = ent(1, 2, 0);
        idx_mem[1] = ent(0, 6, 1);
        model_pass(2, 20);
        run_pass(2, 1);
        compare_pass("overflow");
        chk("ovf_h_writes", h_q.size(), 20);
        chk("ovf_flag", ovf_b, 1'b1);
        chk("ovf_ni_writes", ni_q.size(), 2);

        // Reset in the middle of a pass
        use_b = 1'b0;
        load_plan_index();
        @(negedge clk);
        vld_a = 1'b1; ne_a = 15'd10;
        @(posedge clk);
        #1 vld_a = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("pre_reset_h_ena", h_ena_a, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_h_ena", h_ena_a, 1'b0);
        chk("mid_rst_ni_ena", ni_ena_a, 1'b0);
        chk("mid_rst_feat_addr", feat_addr_a, 0);
        chk("mid_rst_rdy", rdy_a, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        h_q.delete(); ni_q.delete();
        repeat (30) @(negedge clk);
        chk("post_rst_h_writes", h_q.size(), 0);
        chk("post_rst_ni_writes", ni_q.size(), 0);
        chk("post_rst_rdy", rdy_a, 1'b1);
        chk("post_rst_done", done_a, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
